// File: rtl/exe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : exe_pkg                                                 |
// | Description : Shared constants for the execute block.                 |
// |               EXE_WIDTH - default datapath width in bits.             |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package exe_pkg;

  localparam int EXE_WIDTH = 16;

endpackage : exe_pkg
`default_nettype wire

// File: rtl/execute_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : execute_adder                                           |
// | Description : Unsigned WIDTH-bit adder producing a (WIDTH+1)-bit      |
// |               result split into sum and carry.                        |
// | Ports       : a, b  (in,  WIDTH) operands                             |
// |               sum   (out, WIDTH) low WIDTH bits of a + b              |
// |               carry (out, 1)     bit WIDTH of a + b                   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module execute_adder
  import exe_pkg::*;
#(
  parameter int WIDTH = EXE_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Zero-extend both operands so the carry lands in the extra top bit.
  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule : execute_adder
`default_nettype wire

// File: rtl/execute.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : execute                                                 |
// | Description : Add / pass-through stage with combinational outputs     |
// |               and a registered copy plus zero flag.                   |
// | Ports       : clk          (in,  1)     clock, rising edge            |
// |               rst          (in,  1)     synchronous active-high reset |
// |               exe_a        (in,  WIDTH) first operand                 |
// |               exe_b        (in,  WIDTH) second operand / pass value   |
// |               exe_add      (in,  1)     1 = add, 0 = pass exe_b       |
// |               exe_result   (out, WIDTH) combinational result          |
// |               exe_carry    (out, 1)     combinational carry-out       |
// |               exe_result_q (out, WIDTH) registered result             |
// |               exe_carry_q  (out, 1)     registered carry              |
// |               exe_zero_q   (out, 1)     registered result == 0        |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module execute
  import exe_pkg::*;
#(
  parameter int WIDTH = EXE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] exe_a,
  input  logic [WIDTH-1:0] exe_b,
  input  logic             exe_add,
  output logic [WIDTH-1:0] exe_result,
  output logic             exe_carry,
  output logic [WIDTH-1:0] exe_result_q,
  output logic             exe_carry_q,
  output logic             exe_zero_q
);

  logic [WIDTH-1:0] sum;
  logic             sum_carry;

  execute_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (exe_a),
    .b     (exe_b),
    .sum   (sum),
    .carry (sum_carry)
  );

  // Pass-through forces the carry low; exe_a has no effect in that mode.
  always_comb begin
    exe_result = exe_b;
    exe_carry  = 1'b0;
    if (exe_add) begin
      exe_result = sum;
      exe_carry  = sum_carry;
    end
  end

  // Reset value reports a zero result, so the zero flag comes up set.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_result_q <= '0;
      exe_carry_q  <= 1'b0;
      exe_zero_q   <= 1'b1;
    end else begin
      exe_result_q <= exe_result;
      exe_carry_q  <= exe_carry;
      exe_zero_q   <= (exe_result == '0);
    end
  end

endmodule : execute
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_execute                                              |
// | Description : Self-checking bench for execute: directed corner cases  |
// |               followed by random operands against an arithmetic       |
// |               reference model.                                        |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_execute;
  import exe_pkg::*;

  localparam int W = EXE_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] exe_a, exe_b;
  logic         exe_add;
  logic [W-1:0] exe_result, exe_result_q;
  logic         exe_carry, exe_carry_q, exe_zero_q;

  int checks = 0;
  int errors = 0;

  // Reference model of the registered outputs.
  logic [W-1:0] m_res_q;
  logic         m_carry_q;
  logic         m_zero_q;
  bit           m_valid = 1'b0;

  execute #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .exe_a        (exe_a),
    .exe_b        (exe_b),
    .exe_add      (exe_add),
    .exe_result   (exe_result),
    .exe_carry    (exe_carry),
    .exe_result_q (exe_result_q),
    .exe_carry_q  (exe_carry_q),
    .exe_zero_q   (exe_zero_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input set at the falling edge, check the combinational
  // outputs and that the registers still hold, then clock and check the
  // registered outputs against the model.
  task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tadd, input logic trst);
    longint       s;
    longint       modulus;
    logic [W-1:0] er;
    logic         ec;
    modulus = longint'(1) << W;
    @(negedge clk);
    exe_a = ta; exe_b = tb; exe_add = tadd; rst = trst;
    #1;
    s  = tadd ? (longint'(ta) + longint'(tb)) : longint'(tb);
    er = W'(s % modulus);
    ec = tadd && (s >= modulus);
    check("comb_result", 32'(exe_result), 32'(er));
    check("comb_carry",  32'(exe_carry),  32'(ec));
    if (m_valid) begin
      check("hold_result_q", 32'(exe_result_q), 32'(m_res_q));
      check("hold_carry_q",  32'(exe_carry_q),  32'(m_carry_q));
      check("hold_zero_q",   32'(exe_zero_q),   32'(m_zero_q));
    end
    @(posedge clk);
    if (trst) begin
      m_res_q = '0; m_carry_q = 1'b0; m_zero_q = 1'b1;
    end else begin
      m_res_q = er; m_carry_q = ec; m_zero_q = (er == '0);
    end
    m_valid = 1'b1;
    #1;
    check("reg_result_q", 32'(exe_result_q), 32'(m_res_q));
    check("reg_carry_q",  32'(exe_carry_q),  32'(m_carry_q));
    check("reg_zero_q",   32'(exe_zero_q),   32'(m_zero_q));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; exe_a = '0; exe_b = '0; exe_add = 1'b0;

    // Reset state
    apply(16'h1234, 16'h5678, 1'b1, 1'b1);
    check("reset_zero_q", 32'(exe_zero_q), 32'd1);

    // Directed cases
    apply(16'h000A, 16'h0005, 1'b0, 1'b0);
    check("pass_result_q", 32'(exe_result_q), 32'h0005);
    apply(16'h000A, 16'h0005, 1'b1, 1'b0);
    check("add_result_q", 32'(exe_result_q), 32'h000F);

    // Reset while registers hold a nonzero value
    apply(16'h0003, 16'h0004, 1'b1, 1'b1);
    check("mid_rst_result_q", 32'(exe_result_q), 32'h0000);
    check("mid_rst_comb",     32'(exe_result),   32'h0007);

    apply(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    check("wrap_carry_q", 32'(exe_carry_q), 32'd1);
    check("wrap_zero_q",  32'(exe_zero_q),  32'd1);
    apply(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("pass1_zero_q", 32'(exe_zero_q), 32'd0);
    apply(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    apply(16'h8000, 16'h8000, 1'b1, 1'b0);
    apply(16'h0000, 16'h0000, 1'b1, 1'b0);

    // Random operands, occasional reset, biased towards wrap cases
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 4) == 0) rb = W'(-int'(ra));
      apply(ra, rb, 1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 9) == 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_execute
`default_nettype wire

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; all data ports use it.
REQ-002 clk  input  1  single clock; all registered state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; sampled only on the rising edge of clk.
REQ-004 exe_a  input  WIDTH  first operand.
REQ-005 exe_b  input  WIDTH  second operand; pass-through value when no add is requested.
REQ-006 exe_add  input  1  1 selects addition, 0 selects pass-through of exe_b.
REQ-007 exe_result  output  WIDTH  combinational result.
REQ-008 exe_carry  output  1  combinational carry-out of the addition.
REQ-009 exe_result_q  output  WIDTH  registered copy of exe_result.
REQ-010 exe_carry_q  output  1  registered copy of exe_carry.
REQ-011 exe_zero_q  output  1  registered flag, 1 when the registered result equals zero.

Function
REQ-012 When exe_add=1, exe_result SHALL equal (exe_a + exe_b) mod 2^WIDTH, combinationally, with zero latency.
REQ-013 When exe_add=1, exe_carry SHALL equal bit WIDTH of the unsigned (WIDTH+1)-bit sum.
REQ-014 When exe_add=0, exe_result SHALL equal exe_b and exe_carry SHALL be 0; exe_a is ignored.
REQ-015 Operands are unsigned; wrap-around SHALL be silent, with no saturation and no overflow trap (for example, FFFF+0001 gives 0000 with carry 1).
REQ-016 exe_result and exe_carry SHALL respond to input changes without a clock edge and SHALL not depend on clk or rst.
REQ-017 On each rising clk edge with rst=0, exe_result_q, exe_carry_q and exe_zero_q SHALL capture exe_result, exe_carry and (exe_result==0) respectively; latency is 1 cycle.
REQ-018 The registered outputs SHALL hold their value between clock edges regardless of input changes.
REQ-019 exe_zero_q SHALL be 1 for a pass-through of a zero exe_b and for a wrapped sum of zero.

Reset
REQ-020 When rst=1 at a rising clk edge, exe_result_q SHALL become 0, exe_carry_q SHALL become 0, and exe_zero_q SHALL become 1.
REQ-021 An assertion of rst in mid-operation SHALL override capture on that edge; the combinational outputs are unaffected by reset.
REQ-022 The first capture after rst deasserts SHALL occur on the next rising edge with rst=0.

Structure
REQ-023 The default WIDTH constant SHALL reside in a shared package, exe_pkg.
REQ-024 The (WIDTH+1)-bit adder SHALL be a single sub-module, execute_adder (inputs a, b; outputs sum, carry); execute SHALL contain the mux, the output registers and the zero detect.
REQ-025 The block SHALL contain no latches and SHALL use no other clock or reset.

Verification
REQ-026 a=000A, b=0005, add=0 -> exe_result=0005, exe_carry=0; after one edge exe_result_q=0005, exe_zero_q=0.
REQ-027 a=000A, b=0005, add=1 -> exe_result=000F, exe_carry=0 with no clock edge; after the next edge exe_result_q=000F.
REQ-028 a=FFFF, b=0001, add=1 -> exe_result=0000, exe_carry=1; after the next edge exe_carry_q=1, exe_zero_q=1.
REQ-029 a=FFFF, b=0001, add=0 -> exe_result=0001, exe_carry=0; after the next edge exe_zero_q=0.
REQ-030 While the registers hold nonzero values, assert rst for one edge -> exe_result_q=0000, exe_carry_q=0, exe_zero_q=1; exe_result still tracks its inputs.
REQ-031 Change the inputs between edges -> the registered outputs remain unchanged until the next rising edge.
